// File: rtl/uart_link_pkg.sv
// Shared definitions for the inter-tile UART flit link (transmitter and receiver).
// Build option: UART_FLIT_PARITY_EN adds an even-parity bit over the VC and data
// fields. Both ends of a link must be built with the same setting.
package uart_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    VC     = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_FLIT_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Serial bits in one frame: start, VC field, data field, optional parity, stop.
  function automatic int frame_bits(input int flit_width, input int vc_w);
    return 1 + vc_w + flit_width + PARITY_BITS + 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART link. While enabled it emits a one-cycle
// bit_tick_o on the last cycle of every CLKS_PER_BIT-cycle bit period.
// clr_i restarts the period so a new frame always begins on a full bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running modulo counter, held at zero while disabled or cleared.
  always_ff @(posedge clk) begin
    if (rst || clr_i || !en_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bit_tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_flit_tx.sv
// Link-side flit transmitter: one-deep holding register, per-VC credit
// counters and a UART-style serializer (start, VC, data, [parity], stop; LSB first).
// Build option: UART_FLIT_PARITY_EN inserts an even-parity bit after the data field.
//
// state  | meaning
// IDLE   | line high, waiting for the holding register to fill
// START  | driving the start bit
// VC     | shifting out the VC field
// DATA   | shifting out the flit payload
// PARITY | driving the even-parity bit (parity builds only)
// STOP   | driving the stop bit; chains straight into START if a flit is held
module uart_flit_tx
  import uart_link_pkg::*;
#(
  parameter int FLIT_WIDTH   = 32,
  parameter int NUM_VCS      = 2,
  parameter int BUFFER_SIZE  = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int VC_W         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flit_valid,
  output logic                  flit_ready,
  input  logic [FLIT_WIDTH-1:0] flit_data,
  input  logic [VC_W-1:0]       flit_vc,
  input  logic [NUM_VCS-1:0]    credit_return,
  output logic                  uart_tx,
  output logic                  busy
);

  localparam int CRD_W   = $clog2(BUFFER_SIZE + 1);
  localparam int SHIFT_W = VC_W + FLIT_WIDTH;
  localparam int FIELD_MAX = (FLIT_WIDTH > VC_W) ? FLIT_WIDTH : VC_W;
  localparam int BIT_W   = $clog2(FIELD_MAX + 1);
  localparam logic [CRD_W-1:0] CRD_MAX   = CRD_W'(BUFFER_SIZE);
  localparam logic [BIT_W-1:0] VC_LAST   = BIT_W'(VC_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(FLIT_WIDTH - 1);

  tx_state_t              state_q;
  logic                   tx_q;
  logic [SHIFT_W-1:0]     shift_q;
  logic [BIT_W-1:0]       bit_cnt_q;
`ifdef UART_FLIT_PARITY_EN
  logic                   parity_q;
`endif

  logic                   hold_full_q;
  logic [FLIT_WIDTH-1:0]  hold_data_q;
  logic [VC_W-1:0]        hold_vc_q;

  logic                   accept;
  logic                   load;
  logic                   bit_tick;
  logic [NUM_VCS-1:0]     vc_has_credit;

  // Ready depends on the presented VC so a starved VC never blocks the others.
  assign flit_ready = !rst && !hold_full_q && vc_has_credit[flit_vc];
  assign accept     = flit_valid && flit_ready;

  // The held flit moves to the shifter when the line is idle or a stop bit ends.
  assign load = hold_full_q && ((state_q == IDLE) || ((state_q == STOP) && bit_tick));

  assign uart_tx = tx_q;
  assign busy    = (state_q != IDLE) || hold_full_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q != IDLE),
    .clr_i     (load),
    .bit_tick_o(bit_tick)
  );

  // Holding register occupancy: filled on accept, drained on load (never both).
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_full_q <= 1'b1;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

  // Holding register payload; only meaningful while hold_full_q is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data_q <= flit_data;
      hold_vc_q   <= flit_vc;
    end
  end

  // Per-VC credit counters: one spent per accepted flit, one returned per pulse.
  for (genvar v = 0; v < NUM_VCS; v++) begin : g_credit
    logic [CRD_W-1:0] credit_q;
    logic [CRD_W-1:0] credit_d;
    logic             take;
    logic             give;

    assign take = accept && (flit_vc == VC_W'(v));
    assign give = credit_return[v];

    // Net change of the counter; a return at full count is dropped.
    always_comb begin
      credit_d = credit_q;
      if (take && !give) begin
        credit_d = credit_q - CRD_W'(1);
      end else if (give && !take && (credit_q != CRD_MAX)) begin
        credit_d = credit_q + CRD_W'(1);
      end
    end

    // Counter register, refilled to the far-end buffer depth on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        credit_q <= CRD_MAX;
      end else begin
        credit_q <= credit_d;
      end
    end

    assign vc_has_credit[v] = (credit_q != '0);

    // A credit returned while already full means the far end miscounted.
    a_credit_overflow : assert property (@(posedge clk) disable iff (rst)
      !(give && !take && (credit_q == CRD_MAX)));
  end

  // Frame sequencer; uart_tx is registered and updated on bit boundaries only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_q      <= IDLE_LEVEL;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_FLIT_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else if (load) begin
      state_q   <= START;
      tx_q      <= START_BIT;
      shift_q   <= {hold_data_q, hold_vc_q};
      bit_cnt_q <= '0;
`ifdef UART_FLIT_PARITY_EN
      parity_q  <= ^{hold_data_q, hold_vc_q};
`endif
    end else begin
      case (state_q)
        START: begin
          if (bit_tick) begin
            state_q   <= VC;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
          end
        end
        VC: begin
          if (bit_tick) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == VC_LAST) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
`ifdef UART_FLIT_PARITY_EN
              state_q   <= PARITY;
              tx_q      <= parity_q;
`else
              state_q   <= STOP;
              tx_q      <= STOP_BIT;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
`ifdef UART_FLIT_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state_q <= STOP;
            tx_q    <= STOP_BIT;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            state_q <= IDLE;
            tx_q    <= IDLE_LEVEL;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_flit_tx.sv
// Bench for uart_flit_tx at FLIT_WIDTH=8, NUM_VCS=2, BUFFER_SIZE=2, CLKS_PER_BIT=4.
// Honours UART_FLIT_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_flit_tx;

  localparam int FW  = 8;
  localparam int NV  = 2;
  localparam int BS  = 2;
  localparam int CPB = 4;
  localparam int VW  = 1;
`ifdef UART_FLIT_PARITY_EN
  localparam int SPAN3 = 146;
`else
  localparam int SPAN3 = 134;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flit_valid = 1'b0;
  logic          flit_ready;
  logic [FW-1:0] flit_data = '0;
  logic [VW-1:0] flit_vc = '0;
  logic [NV-1:0] credit_return = '0;
  logic          uart_tx;
  logic          busy;

  uart_flit_tx #(
    .FLIT_WIDTH  (FW),
    .NUM_VCS     (NV),
    .BUFFER_SIZE (BS),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_valid   (flit_valid),
    .flit_ready   (flit_ready),
    .flit_data    (flit_data),
    .flit_vc      (flit_vc),
    .credit_return(credit_return),
    .uart_tx      (uart_tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-cycle expected line levels as a queue of samples.
  bit line_q[$];
  bit hold_q[$];
  bit m_hold = 1'b0;
  int m_credit[NV];
  bit chk_en = 1'b0;

  initial foreach (m_credit[v]) m_credit[v] = BS;

  always begin : model_cmp
    bit e_tx;
    bit e_busy;
    bit e_rdy;
    bit acc;
    bit fr[$];
    @(negedge clk);
    #3;
    if (chk_en) begin
      e_tx   = (line_q.size() > 0) ? line_q[0] : 1'b1;
      e_busy = m_hold || (line_q.size() > 0);
      e_rdy  = !rst && !m_hold && (m_credit[int'(flit_vc)] > 0);
      check("uart_tx", uart_tx, e_tx);
      check("busy", busy, e_busy);
      check("flit_ready", flit_ready, e_rdy);
      if (rst) begin
        line_q.delete();
        hold_q.delete();
        m_hold = 1'b0;
        foreach (m_credit[v]) m_credit[v] = BS;
      end else begin
        acc = flit_valid && e_rdy;
        if (line_q.size() > 0) void'(line_q.pop_front());
        if (line_q.size() == 0 && m_hold) begin
          line_q = hold_q;
          m_hold = 1'b0;
        end
        if (acc) begin
          fr.delete();
          fr.push_back(1'b0);
          for (int i = 0; i < VW; i++) fr.push_back(flit_vc[i]);
          for (int i = 0; i < FW; i++) fr.push_back(flit_data[i]);
`ifdef UART_FLIT_PARITY_EN
          fr.push_back(bit'(($countones(flit_data) + $countones(flit_vc)) % 2));
`endif
          fr.push_back(1'b1);
          hold_q.delete();
          foreach (fr[i]) for (int r = 0; r < CPB; r++) hold_q.push_back(fr[i]);
          m_hold = 1'b1;
        end
        for (int v = 0; v < NV; v++) begin
          m_credit[v] = m_credit[v] - ((acc && int'(flit_vc) == v) ? 1 : 0)
                        + (credit_return[v] ? 1 : 0);
          if (m_credit[v] > BS) m_credit[v] = BS;
        end
      end
    end
  end

  // All driver tasks start and end exactly at a falling clock edge.
  task automatic send(input logic [FW-1:0] d, input logic [VW-1:0] vc,
                      input logic [NV-1:0] cr, output int acc_cyc);
    int n;
    n = 0;
    flit_data = d;
    flit_vc = vc;
    flit_valid = 1'b1;
    credit_return = cr;
    #3;
    while (flit_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      credit_return = '0;
      #3;
      n++;
    end
    acc_cyc = cyc;
    check("send_ready", flit_ready, 1);
    @(negedge clk);
    flit_valid = 1'b0;
    credit_return = '0;
  endtask

  task automatic wait_idle(output int c);
    int n;
    n = 0;
    #3;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("idle_reached", busy, 0);
    c = cyc;
    @(negedge clk);
  endtask

  task automatic probe(input logic [VW-1:0] vc, input bit exp, input string name);
    flit_valid = 1'b0;
    flit_vc = vc;
    #3;
    check(name, flit_ready, exp);
    @(negedge clk);
  endtask

  int lit_q[$];

  // Called right after send(): checks latency and every bit of the frame.
  task automatic check_frame(input string tag);
    #3;
    check({tag, "_pre_start"}, uart_tx, 1);
    @(negedge clk);
    #3;
    check({tag, "_start_edge"}, uart_tx, 0);
    foreach (lit_q[i]) begin
      @(negedge clk);
      #3;
      check($sformatf("%s_bit%0d", tag, i), uart_tx, lit_q[i]);
      repeat (CPB - 1) @(negedge clk);
    end
    #3;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_idle_after"}, uart_tx, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a1, a2, a3, c;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    flit_valid = 1'b1;
    flit_vc = 1'b0;
    #3;
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready_forced0", flit_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    flit_valid = 1'b0;
    #3;
    check("post_rst_ready", flit_ready, 1);
    @(negedge clk);

    // Single flit 0xA5 on VC1.
`ifdef UART_FLIT_PARITY_EN
    lit_q = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`else
    lit_q = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
    send(8'hA5, 1'b1, '0, a1);
    check_frame("a5");
    credit_return = 2'b10;
    @(negedge clk);
    credit_return = '0;

    // Back-to-back frames and VC0 credit exhaustion; VC1 keeps flowing.
    send(8'h3C, 1'b0, '0, a1);
    send(8'hC3, 1'b0, '0, a2);
    check("b2b_accept_gap", a2 - a1, 2);
    send(8'h5A, 1'b1, '0, a3);
    wait_idle(c);
    check("b2b_busy_span", c - a1, SPAN3);
    probe(1'b0, 1'b0, "vc0_exhausted");
    probe(1'b1, 1'b1, "vc1_unaffected");
    flit_vc = 1'b0;
    credit_return = 2'b01;
    #3;
    check("cr_same_cycle", flit_ready, 0);
    @(negedge clk);
    credit_return = '0;
    #3;
    check("cr_next_cycle", flit_ready, 1);
    @(negedge clk);

    // Accept and credit return on VC0 in the same cycle with one credit left.
    send(8'h81, 1'b0, 2'b01, a1);
    wait_idle(c);
    probe(1'b0, 1'b1, "simul_credit_kept");
    send(8'h18, 1'b0, '0, a1);
    wait_idle(c);
    probe(1'b0, 1'b0, "simul_credit_was_one");
    credit_return = 2'b11;
    @(negedge clk);
    credit_return = 2'b01;
    @(negedge clk);
    credit_return = '0;
    @(negedge clk);

    // Reset in the middle of the data field.
    send(8'hF0, 1'b0, '0, a1);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    flit_valid = 1'b1;
    flit_vc = 1'b1;
    #3;
    check("midrst_ready_forced0", flit_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    flit_valid = 1'b0;
    #3;
    check("midrst_line_high", uart_tx, 1);
    check("midrst_busy_clear", busy, 0);
    @(negedge clk);
    send(8'h11, 1'b0, '0, a1);
    send(8'h22, 1'b0, '0, a2);
    check("midrst_credits_full", a2 - a1, 2);
    wait_idle(c);
    credit_return = 2'b01;
    @(negedge clk);
    @(negedge clk);
    credit_return = '0;
    @(negedge clk);

    // Parity-relevant payloads on VC0.
`ifdef UART_FLIT_PARITY_EN
    lit_q = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
`else
    lit_q = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
`endif
    send(8'h03, 1'b0, '0, a1);
    check_frame("d03");
`ifdef UART_FLIT_PARITY_EN
    lit_q = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
`else
    lit_q = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
`endif
    send(8'h07, 1'b0, '0, a1);
    check_frame("d07");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
